// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer RAM arbiter: display line prefetch over draw-client writes
//
// Shares one single-port frame-buffer RAM between a line prefetcher (high priority)
// and a drawing client (valid/ready, low priority). During each horizontal blanking
// interval the next visible line is read into a ping-pong line buffer.
//
// Ports:
//   clk, rst_n            pixel clock, synchronous active-low reset
//   xcounter, ycounter    free-running position from the VGA sync generator
//   wr_valid/wr_ready     draw client handshake; wr_addr/wr_data write word
//   mem_en/mem_we         RAM strobe / write select; mem_addr, mem_wdata, mem_rdata
//   lb_we/lb_bank/lb_addr/lb_wdata   line-buffer write port
//   busy                  prefetch in progress
//   fetch_err             sticky: prefetch still running at xcounter==H_MAX

module vga_fb_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int H_MAX    = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_MAX    = 525,
    parameter int WORDS    = 80,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        xcounter,
    input  logic [9:0]        ycounter,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [6:0]        lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              busy,
    output logic              fetch_err
);

    // The word index must be able to count to WORDS-1 even when a line is wider
    // than the 7-bit line-buffer address; lb_addr then carries its low bits.
    localparam int IDX_W = (WORDS > 128) ? $clog2(WORDS) : 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_base;
    logic              r_bank;
    logic              r_lb_we;
    logic [6:0]        r_lb_addr;
    logic              r_fetch_err;

    logic [9:0]        w_next_y;
    logic              w_trig;
    logic [ADDR_W-1:0] w_base;
    logic              w_wr_ready;
    logic              w_last;

    // The line fetched is the one after the current ycounter; the last scan line
    // of the frame wraps to line 0 so the first visible line is ready in time.
    assign w_next_y   = (ycounter == 10'(V_MAX)) ? 10'd0 : ycounter + 10'd1;
    assign w_trig     = (xcounter == 10'(H_ACTIVE)) && (w_next_y < 10'(V_ACTIVE));
    assign w_base     = ADDR_W'(w_next_y) * ADDR_W'(WORDS);
    assign w_last     = (r_idx == IDX_W'(WORDS - 1));
    // Prefetch wins on the trigger cycle itself, so the write waits for IDLE.
    assign w_wr_ready = (r_state == ST_IDLE) && !w_trig && rst_n;

    assign wr_ready  = w_wr_ready;
    assign lb_we     = r_lb_we;
    assign lb_bank   = r_bank;
    assign lb_addr   = r_lb_addr;
    assign lb_wdata  = r_lb_we ? mem_rdata : '0;
    assign fetch_err = r_fetch_err;

    always_comb begin
        w_next_state = r_state;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_next_state = ST_FETCH;
                end else if (wr_valid && w_wr_ready) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end
            end
            ST_FETCH: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = r_base + ADDR_W'(r_idx);
                if (w_last) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_base      <= '0;
            r_bank      <= 1'b0;
            r_lb_we     <= 1'b0;
            r_lb_addr   <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // A read issued this cycle returns next cycle; capture it then.
            r_lb_we <= (r_state == ST_FETCH);
            if (r_state == ST_FETCH) begin
                r_lb_addr <= 7'(r_idx);
                r_idx     <= r_idx + 1'b1;
            end else if (r_state == ST_IDLE && w_trig) begin
                r_base <= w_base;
                r_bank <= w_next_y[0];
                r_idx  <= '0;
            end
            if (r_state != ST_IDLE && xcounter == 10'(H_MAX)) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter

module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  xcounter, ycounter;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        lb_we, lb_bank, busy, fetch_err;
    logic [6:0]  lb_addr;
    logic [31:0] lb_wdata;

    logic        wr_ready2, mem_en2, mem_we2, lb_we2, lb_bank2, busy2, fetch_err2;
    logic [15:0] mem_addr2;
    logic [31:0] mem_wdata2, mem_rdata2, lb_wdata2;
    logic [6:0]  lb_addr2;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .xcounter(xcounter), .ycounter(ycounter),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr),
        .lb_wdata(lb_wdata), .busy(busy), .fetch_err(fetch_err)
    );

    vga_fb_arbiter #(.WORDS(200)) dut2 (
        .clk(clk), .rst_n(rst_n), .xcounter(xcounter), .ycounter(ycounter),
        .wr_valid(1'b0), .wr_ready(wr_ready2), .wr_addr(16'h0), .wr_data(32'h0),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .lb_we(lb_we2), .lb_bank(lb_bank2), .lb_addr(lb_addr2),
        .lb_wdata(lb_wdata2), .busy(busy2), .fetch_err(fetch_err2)
    );

    // Frame-buffer RAM seen by the DUT, and the bench's own view of its contents.
    logic [31:0] ram     [0:65535];
    logic [31:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
        if (mem_en2 && !mem_we2) mem_rdata2 <= {16'hA5A5, mem_addr2};
    end

    typedef struct { int cyc; logic [15:0] a; } rd_t;
    typedef struct { int cyc; logic [6:0] a; logic bank; logic [31:0] d; } lb_t;
    typedef struct { int x; logic [15:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [15:0] a; logic [31:0] d; } req_t;

    rd_t  rd_q[$];
    lb_t  lb_q[$];
    lb_t  lb2_q[$];
    wr_t  wr_q[$];
    req_t cq[$];
    int   busy_cnt;
    int   cyc = 0;
    int   passed = 0, total = 0, failed = 0;
    logic jump = 1'b0;
    logic [9:0] jx, jy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        rd_q.delete(); lb_q.delete(); lb2_q.delete(); wr_q.delete();
        busy_cnt = 0;
    endtask

    task automatic jump_to(input int nx, input int ny);
        jx = 10'(nx); jy = 10'(ny); jump = 1'b1;
    endtask

    // One pixel clock: advance the sync counters, run the draw client, then record.
    task automatic tick();
        logic acc;
        acc = wr_valid && wr_ready;
        @(posedge clk);
        #1;
        if (jump) begin
            xcounter = jx; ycounter = jy; jump = 1'b0;
        end else if (xcounter == 10'd800) begin
            xcounter = 10'd0;
            ycounter = (ycounter == 10'd525) ? 10'd0 : ycounter + 10'd1;
        end else begin
            xcounter = xcounter + 10'd1;
        end
        if (acc && cq.size() > 0) void'(cq.pop_front());
        wr_valid = (cq.size() > 0);
        wr_addr  = (cq.size() > 0) ? cq[0].a : 16'h0;
        wr_data  = (cq.size() > 0) ? cq[0].d : 32'h0;
        #2;
        cyc++;
        if (mem_en && !mem_we) rd_q.push_back('{cyc, mem_addr});
        if (mem_en && mem_we)  wr_q.push_back('{int'(xcounter), mem_addr, mem_wdata});
        if (lb_we)  lb_q.push_back('{cyc, lb_addr, lb_bank, lb_wdata});
        if (lb_we2) lb2_q.push_back('{cyc, lb_addr2, lb_bank2, lb_wdata2});
        if (busy) busy_cnt++;
    endtask

    task automatic push_write(input logic [15:0] a, input logic [31:0] d);
        cq.push_back('{a, d});
        ref_mem[a] = d;
    endtask

    // Expected line fetch from the rules: WORDS consecutive reads of line*80+k,
    // each landing in the line buffer one cycle later, busy for WORDS+1 cycles.
    task automatic check_fetch(input string t, input int line);
        int base;
        base = line * 80;
        chk({t, "_nreads"}, rd_q.size(), 80);
        chk({t, "_nlb"}, lb_q.size(), 80);
        chk({t, "_busy_cycles"}, busy_cnt, 81);
        for (int k = 0; k < 80 && k < rd_q.size(); k++) begin
            chk($sformatf("%s_rd_addr[%0d]", t, k), rd_q[k].a, 64'(base + k));
            chk($sformatf("%s_rd_cyc[%0d]", t, k), rd_q[k].cyc, rd_q[0].cyc + k);
            if (k < lb_q.size()) begin
                chk($sformatf("%s_lb_addr[%0d]", t, k), lb_q[k].a, 64'(k));
                chk($sformatf("%s_lb_data[%0d]", t, k), lb_q[k].d, ref_mem[base + k]);
                chk($sformatf("%s_lb_bank[%0d]", t, k), lb_q[k].bank, 64'(line % 2));
                chk($sformatf("%s_lb_cyc[%0d]", t, k), lb_q[k].cyc, rd_q[k].cyc + 1);
            end
        end
    endtask

    initial begin
        int xs[5];
        logic [31:0] v;
        for (int a = 0; a < 65536; a++) begin
            v = $urandom;
            ram[a] = v;
            ref_mem[a] = v;
        end
        rst_n = 1'b0; xcounter = 10'd100; ycounter = 10'd100;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        clear_obs();

        // 1: reset with a write pending
        push_write(16'h0042, $urandom);
        repeat (3) tick();
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_lb_we", lb_we, 0);
        chk("rst_lb_addr", lb_addr, 0);
        chk("rst_lb_wdata", lb_wdata, 0);
        chk("rst_lb_bank", lb_bank, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_no_mem_write", wr_q.size(), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_write_cnt", wr_q.size(), 1);
        if (wr_q.size() > 0) chk("post_rst_write_addr", wr_q[0].a, 16'h0042);
        tick();

        // 2: line fetch for y=9 -> line 10, base 800
        clear_obs(); jump_to(640, 9); tick();
        chk("t2_trig_wr_ready", wr_ready, 0);
        chk("t2_trig_busy", busy, 0);
        repeat (83) tick();
        chk("t2_busy_after", busy, 0);
        check_fetch("t2", 10);

        // 3: frame wrap fetches line 0; no fetch on last visible / blanking lines
        clear_obs(); jump_to(640, 525); repeat (84) tick();
        check_fetch("t3", 0);
        clear_obs(); jump_to(640, 479); tick();
        chk("t3_479_wr_ready", wr_ready, 1);
        repeat (5) tick();
        chk("t3_479_nreads", rd_q.size(), 0);
        chk("t3_479_busy", busy_cnt, 0);
        clear_obs(); jump_to(640, 500); repeat (6) tick();
        chk("t3_500_nreads", rd_q.size(), 0);
        chk("t3_500_busy", busy_cnt, 0);

        // 4: writes contending with the prefetch of line 21
        clear_obs();
        for (int j = 0; j < 5; j++) push_write(16'h1234 + 16'(j), $urandom);
        jump_to(638, 20);
        repeat (130) tick();
        xs = '{638, 639, 722, 723, 724};
        chk("t4_nwrites", wr_q.size(), 5);
        chk("t4_client_drained", cq.size(), 0);
        for (int j = 0; j < 5 && j < wr_q.size(); j++) begin
            chk($sformatf("t4_wr_x[%0d]", j), wr_q[j].x, xs[j]);
            chk($sformatf("t4_wr_addr[%0d]", j), wr_q[j].a, 64'(16'h1234 + j));
            chk($sformatf("t4_wr_data[%0d]", j), wr_q[j].d, ref_mem[16'h1234 + j]);
        end
        check_fetch("t4", 21);
        clear_obs(); jump_to(640, 57); repeat (84) tick();
        check_fetch("t4rb", 58);

        // 5: reset in mid-fetch, then a full refetch
        clear_obs(); jump_to(640, 30); tick();
        repeat (41) tick();
        chk("t5_word40_addr", mem_addr, 64'(31 * 80 + 40));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_lb_we_after_rst", lb_we, 0);
        chk("t5_mem_en_after_rst", mem_en, 0);
        clear_obs(); jump_to(640, 30); repeat (84) tick();
        check_fetch("t5", 31);

        // 6: 200-word line overruns the blanking interval
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t6_err_after_rst", fetch_err2, 0);
        clear_obs(); jump_to(640, 40); tick();
        repeat (159) tick();
        chk("t6_x799", xcounter, 799);
        chk("t6_busy_at_799", busy2, 1);
        chk("t6_err_at_799", fetch_err2, 0);
        tick();
        tick();
        chk("t6_err_after_800", fetch_err2, 1);
        repeat (50) tick();
        chk("t6_err_sticky", fetch_err2, 1);
        chk("t6_busy_done", busy2, 0);
        chk("t6_nlb", lb2_q.size(), 200);
        for (int k = 0; k < 200 && k < lb2_q.size(); k++) begin
            chk($sformatf("t6_lb_addr[%0d]", k), lb2_q[k].a, 64'(k % 128));
            chk($sformatf("t6_lb_data[%0d]", k), lb2_q[k].d, {16'hA5A5, 16'(41 * 200 + k)});
            chk($sformatf("t6_lb_bank[%0d]", k), lb2_q[k].bank, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
